// File: rtl/sprite_palette_arbiter.sv
// Round-robin arbiter sharing one palette lookup port between sprite requesters.
// The grant is combinational; the palette result is registered with its owner ID and a colour-key flag.
module sprite_palette_arbiter #(
    parameter int N_REQ  = 3,
    parameter int IDX_W  = 4,
    parameter int BANK_W = 2,
    parameter int CNT_W  = 16,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    frame_start_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*IDX_W-1:0]  req_index_i,
    input  logic [N_REQ*BANK_W-1:0] req_bank_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic [IDX_W-1:0]        pal_index_o,
    output logic [BANK_W-1:0]       pal_bank_o,
    input  logic [11:0]             pal_rgb_i,
    output logic                    rsp_valid_o,
    output logic [ID_W-1:0]         rsp_id_o,
    output logic [3:0]              rsp_red_o,
    output logic [3:0]              rsp_green_o,
    output logic [3:0]              rsp_blue_o,
    output logic                    rsp_transparent_o,
    output logic [CNT_W-1:0]        lookup_count_o
);

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             win_vld;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  cand;
    int               cand_int;

    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             transp_q, transp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Search starts one past the last winner, so the last winner ranks lowest.
    always_comb begin
        win_vld  = 1'b0;
        win_id   = '0;
        cand_int = 0;
        cand     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand_int = int'(ptr_q) + i;
            if (cand_int >= N_REQ) cand_int = cand_int - N_REQ;
            cand = ID_W'(cand_int);
            if (!win_vld && req_i[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    always_comb begin
        gnt_o       = '0;
        pal_index_o = '0;
        pal_bank_o  = '0;
        if (win_vld) begin
            gnt_o[win_id] = 1'b1;
            pal_index_o   = req_index_i[int'(win_id)*IDX_W +: IDX_W];
            pal_bank_o    = req_bank_i[int'(win_id)*BANK_W +: BANK_W];
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        rsp_id_d = rsp_id_q;
        rgb_d    = rgb_q;
        transp_d = transp_q;
        if (win_vld) begin
            ptr_d    = win_id;
            rsp_id_d = win_id;
            rgb_d    = pal_rgb_i;
            transp_d = (pal_index_o == '0);
        end
    end

    // frame_start restarts the count, counting a grant in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (frame_start_i)
            cnt_d = win_vld ? CNT_W'(1) : '0;
        else if (win_vld && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q       <= ID_W'(N_REQ - 1);
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rgb_q       <= '0;
            transp_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= win_vld;
            rsp_id_q    <= rsp_id_d;
            rgb_q       <= rgb_d;
            transp_q    <= transp_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rsp_valid_o       = rsp_valid_q;
    assign rsp_id_o          = rsp_id_q;
    assign rsp_red_o         = rgb_q[11:8];
    assign rsp_green_o       = rgb_q[7:4];
    assign rsp_blue_o        = rgb_q[3:0];
    assign rsp_transparent_o = transp_q;
    assign lookup_count_o    = cnt_q;

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Directed bench for sprite_palette_arbiter: vector table plus saturation and async-reset sequences.
module tb_sprite_palette_arbiter;

    localparam int N_REQ  = 3;
    localparam int IDX_W  = 4;
    localparam int BANK_W = 2;
    localparam int CNT_W  = 4;
    localparam int ID_W   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    fs;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*IDX_W-1:0]  idx;
    logic [N_REQ*BANK_W-1:0] bank;
    logic [N_REQ-1:0]        gnt;
    logic [IDX_W-1:0]        pidx;
    logic [BANK_W-1:0]       pbank;
    logic [11:0]             rgb;
    logic                    rvld;
    logic [ID_W-1:0]         rid;
    logic [3:0]              rr, rg, rb;
    logic                    rt;
    logic [CNT_W-1:0]        cnt;

    int n_cmp = 0;
    int n_err = 0;
    bit inv_on = 1'b0;

    sprite_palette_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W), .BANK_W(BANK_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .frame_start_i(fs), .req_i(req), .req_index_i(idx),
        .req_bank_i(bank), .gnt_o(gnt), .pal_index_o(pidx), .pal_bank_o(pbank),
        .pal_rgb_i(rgb), .rsp_valid_o(rvld), .rsp_id_o(rid), .rsp_red_o(rr),
        .rsp_green_o(rg), .rsp_blue_o(rb), .rsp_transparent_o(rt), .lookup_count_o(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [11:0] idx;
        logic [5:0]  bank;
        logic [11:0] rgb;
        logic        fs;
        logic [2:0]  e_gnt;
        logic [3:0]  e_pidx;
        logic [1:0]  e_pbank;
        logic        e_vld;
        logic [1:0]  e_id;
        logic [11:0] e_rgb;
        logic        e_t;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tv[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Invariants on the grant vector, sampled on the falling edge.
    always @(negedge clk) begin
        if (inv_on) begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("gnt_implies_req", 32'(gnt & ~req), 32'd0);
        end
    end

    initial begin
        //         req     idx      bank       rgb     fs    gnt     pidx  pb  vld id  rgb     t  cnt
        tv[0]  = '{3'b111, 12'h321, 6'b100100, 12'h123, 0, 3'b001, 4'h1, 2'd0, 1, 2'd0, 12'h123, 0, 4'd1};
        tv[1]  = '{3'b111, 12'h321, 6'b100100, 12'h123, 0, 3'b010, 4'h2, 2'd1, 1, 2'd1, 12'h123, 0, 4'd2};
        tv[2]  = '{3'b111, 12'h321, 6'b100100, 12'h123, 0, 3'b100, 4'h3, 2'd2, 1, 2'd2, 12'h123, 0, 4'd3};
        tv[3]  = '{3'b111, 12'h321, 6'b100100, 12'h123, 0, 3'b001, 4'h1, 2'd0, 1, 2'd0, 12'h123, 0, 4'd4};
        tv[4]  = '{3'b111, 12'h321, 6'b100100, 12'h123, 0, 3'b010, 4'h2, 2'd1, 1, 2'd1, 12'h123, 0, 4'd5};
        tv[5]  = '{3'b111, 12'h321, 6'b100100, 12'h123, 0, 3'b100, 4'h3, 2'd2, 1, 2'd2, 12'h123, 0, 4'd6};
        tv[6]  = '{3'b010, 12'h750, 6'b100111, 12'hC95, 0, 3'b010, 4'h5, 2'd1, 1, 2'd1, 12'hC95, 0, 4'd7};
        tv[7]  = '{3'b001, 12'h750, 6'b100111, 12'hF0F, 0, 3'b001, 4'h0, 2'd3, 1, 2'd0, 12'hF0F, 1, 4'd8};
        tv[8]  = '{3'b000, 12'h750, 6'b100111, 12'h0AA, 0, 3'b000, 4'h0, 2'd0, 0, 2'd0, 12'hF0F, 1, 4'd8};
        tv[9]  = '{3'b100, 12'h750, 6'b100111, 12'h777, 0, 3'b100, 4'h7, 2'd2, 1, 2'd2, 12'h777, 0, 4'd9};
        tv[10] = '{3'b101, 12'h754, 6'b100101, 12'h444, 0, 3'b001, 4'h4, 2'd1, 1, 2'd0, 12'h444, 0, 4'd10};
        tv[11] = '{3'b000, 12'h754, 6'b100101, 12'h0AA, 0, 3'b000, 4'h0, 2'd0, 0, 2'd0, 12'h444, 0, 4'd10};
        tv[12] = '{3'b000, 12'h754, 6'b100101, 12'h0BB, 0, 3'b000, 4'h0, 2'd0, 0, 2'd0, 12'h444, 0, 4'd10};
        tv[13] = '{3'b101, 12'h754, 6'b100101, 12'h777, 0, 3'b100, 4'h7, 2'd2, 1, 2'd2, 12'h777, 0, 4'd11};
        tv[14] = '{3'b101, 12'h754, 6'b100101, 12'h444, 0, 3'b001, 4'h4, 2'd1, 1, 2'd0, 12'h444, 0, 4'd12};
        tv[15] = '{3'b010, 12'h754, 6'b100101, 12'hC95, 1, 3'b010, 4'h5, 2'd1, 1, 2'd1, 12'hC95, 0, 4'd1};
        tv[16] = '{3'b000, 12'h754, 6'b100101, 12'h0AA, 1, 3'b000, 4'h0, 2'd0, 0, 2'd1, 12'hC95, 0, 4'd0};

        rst = 1'b1; fs = 1'b0; req = '0; idx = '0; bank = '0; rgb = '0;
        #12;
        chk("reset_rsp_valid", 32'(rvld), 32'd0);
        chk("reset_rsp_id", 32'(rid), 32'd0);
        chk("reset_rgb", 32'({rr, rg, rb}), 32'd0);
        chk("reset_transp", 32'(rt), 32'd0);
        chk("reset_count", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        inv_on = 1'b1;

        for (int i = 0; i < 17; i++) begin
            req = tv[i].req; idx = tv[i].idx; bank = tv[i].bank; rgb = tv[i].rgb; fs = tv[i].fs;
            #1;
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tv[i].e_gnt));
            chk($sformatf("v%0d_pal_index", i), 32'(pidx), 32'(tv[i].e_pidx));
            chk($sformatf("v%0d_pal_bank", i), 32'(pbank), 32'(tv[i].e_pbank));
            @(posedge clk); #1;
            chk($sformatf("v%0d_rsp_valid", i), 32'(rvld), 32'(tv[i].e_vld));
            chk($sformatf("v%0d_rsp_id", i), 32'(rid), 32'(tv[i].e_id));
            chk($sformatf("v%0d_rsp_rgb", i), 32'({rr, rg, rb}), 32'(tv[i].e_rgb));
            chk($sformatf("v%0d_rsp_transp", i), 32'(rt), 32'(tv[i].e_t));
            chk($sformatf("v%0d_count", i), 32'(cnt), 32'(tv[i].e_cnt));
        end

        // Saturation: count is 0 here; 15 grants reach the 4-bit maximum, the 16th must hold.
        fs = 1'b0; req = 3'b111; rgb = 12'h321;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (i == 15) chk("sat_reach_max", 32'(cnt), 32'd15);
            if (i == 16) chk("sat_hold_max", 32'(cnt), 32'd15);
        end
        fs = 1'b1; req = 3'b000;
        @(posedge clk); #1;
        chk("frame_start_clear", 32'(cnt), 32'd0);
        fs = 1'b0;

        // Async reset mid-stream: outputs clear without waiting for a clock edge.
        req = 3'b111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_valid", 32'(rvld), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(rvld), 32'd0);
        chk("async_rst_count", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        chk("in_rst_valid", 32'(rvld), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("post_rst_gnt", 32'(gnt), 32'b001);
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(rvld), 32'd1);
        chk("post_rst_id", 32'(rid), 32'd0);
        chk("post_rst_count", 32'(cnt), 32'd1);
        req = 3'b000;
        @(posedge clk); #1;
        inv_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
